amm_cfg_master: RTL and testbench

Avalon-MM initiator that programs and checks the key-pattern control register block from a single start command. On start it disables matching and writes all key-symbol words. It then writes the enable word and, if requested, reads every register back and compares it with what was written. It sits between the host/test sequencer and the control register slave, and drives the slave's avalon_mm_if.

---
 rtl/amm_cfg_master.sv | 215 +++++++++++++++++++++
 tb/tb_amm_cfg_master.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/amm_cfg_master.sv
// Avalon-MM initiator that loads the key-pattern control block from one start
// command: disable, write key symbols, write enable, then optionally read back.
module amm_cfg_master #(
    parameter int REG_WIDTH  = 32,
    parameter int REG_DEPTH  = 4,
    parameter int PAT_WIDTH  = REG_DEPTH - 1,
    parameter int PAT_SIZE   = PAT_WIDTH * REG_WIDTH,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  start_i,
    input  logic [0:PAT_SIZE-1]   pattern_i,
    input  logic                  enable_i,
    input  logic                  verify_i,
    output logic [ADDR_WIDTH-1:0] amm_address,
    output logic                  amm_write,
    output logic [REG_WIDTH-1:0]  amm_writedata,
    output logic                  amm_read,
    input  logic                  amm_waitrequest,
    input  logic [REG_WIDTH-1:0]  amm_readdata,
    input  logic                  amm_readdatavalid,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_DIS  = 3'd1;
    localparam logic [2:0] S_WR_PAT  = 3'd2;
    localparam logic [2:0] S_WR_EN   = 3'd3;
    localparam logic [2:0] S_RD_REQ  = 3'd4;
    localparam logic [2:0] S_RD_WAIT = 3'd5;
    localparam logic [2:0] S_FIN     = 3'd6;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]         TMAX      = TW'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PAT_WIDTH);

    logic [2:0]            state_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [TW-1:0]         timer_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    logic [REG_WIDTH-1:0]  pat_q [PAT_WIDTH];
    logic                  en_q;
    logic                  verify_q;

    logic [REG_WIDTH-1:0]  en_word;
    logic [REG_WIDTH-1:0]  pat_sel;
    logic [REG_WIDTH-1:0]  exp_word;
    logic                  rd_take;
    logic                  timed_out;

    // Shadow copies of the command; loaded only on an accepted start.
    always_ff @(posedge clk_i) begin
        if (state_q == S_IDLE && start_i) begin
            for (int i = 0; i < PAT_WIDTH; i++) begin
                pat_q[i] <= pattern_i[REG_WIDTH*i +: REG_WIDTH];
            end
            en_q     <= enable_i;
            verify_q <= verify_i;
        end
    end

    assign en_word = {{(REG_WIDTH-1){1'b0}}, en_q};

    always_comb begin
        pat_sel = '0;
        for (int i = 0; i < PAT_WIDTH; i++) begin
            if (idx_q == ADDR_WIDTH'(i + 1)) begin
                pat_sel = pat_q[i];
            end
        end
    end

    assign exp_word  = (idx_q == '0) ? en_word : pat_sel;
    assign rd_take   = ((state_q == S_RD_REQ) && !amm_waitrequest && amm_readdatavalid) ||
                       ((state_q == S_RD_WAIT) && amm_readdatavalid);
    assign timed_out = (state_q == S_RD_WAIT) && !amm_readdatavalid && (timer_q == TMAX);

    // Bus outputs decode straight from state so they hold steady under waitrequest.
    always_comb begin
        amm_write     = 1'b0;
        amm_read      = 1'b0;
        amm_address   = '0;
        amm_writedata = '0;
        case (state_q)
            S_WR_DIS: begin
                amm_write = 1'b1;
            end
            S_WR_PAT: begin
                amm_write     = 1'b1;
                amm_address   = idx_q;
                amm_writedata = pat_sel;
            end
            S_WR_EN: begin
                amm_write     = 1'b1;
                amm_writedata = en_word;
            end
            S_RD_REQ: begin
                amm_read    = 1'b1;
                amm_address = idx_q;
            end
            S_RD_WAIT: begin
                amm_address = idx_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            timer_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_WR_DIS;
                        busy_q     <= 1'b1;
                        error_q    <= 1'b0;
                        err_addr_q <= '0;
                        idx_q      <= '0;
                    end
                end
                S_WR_DIS: begin
                    if (!amm_waitrequest) begin
                        state_q <= S_WR_PAT;
                        idx_q   <= ADDR_WIDTH'(1);
                    end
                end
                S_WR_PAT: begin
                    if (!amm_waitrequest) begin
                        if (idx_q == LAST_ADDR) begin
                            state_q <= S_WR_EN;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_WR_EN: begin
                    if (!amm_waitrequest) begin
                        if (verify_q) begin
                            state_q <= S_RD_REQ;
                            idx_q   <= '0;
                        end else begin
                            state_q <= S_FIN;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (!amm_waitrequest) begin
                        if (amm_readdatavalid) begin
                            if (idx_q == LAST_ADDR) begin
                                state_q <= S_FIN;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            state_q <= S_RD_WAIT;
                            timer_q <= '0;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (amm_readdatavalid) begin
                        if (idx_q == LAST_ADDR) begin
                            state_q <= S_FIN;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= S_RD_REQ;
                        end
                    end else if (timer_q == TMAX) begin
                        state_q <= S_FIN;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Only the first failure of a sequence is kept.
            if (!error_q && ((rd_take && (amm_readdata != exp_word)) || timed_out)) begin
                error_q    <= 1'b1;
                err_addr_q <= idx_q;
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign error_o    = error_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_amm_cfg_master.sv
// Directed bench for amm_cfg_master with a configurable Avalon-MM slave model.
module tb_amm_cfg_master;

    localparam int RW = 32;
    localparam int PW = 3;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            arst_n;
    logic            start;
    logic [0:PW*RW-1] pattern;
    logic            enable, verify;
    logic [AW-1:0]   address;
    logic            write, read;
    logic [RW-1:0]   writedata;
    logic            waitreq;
    logic [RW-1:0]   rdata;
    logic            rdv;
    logic            busy, done, error;
    logic [AW-1:0]   err_addr;

    always #5 clk = ~clk;

    amm_cfg_master dut (
        .clk_i(clk), .arst_n_i(arst_n), .start_i(start), .pattern_i(pattern),
        .enable_i(enable), .verify_i(verify),
        .amm_address(address), .amm_write(write), .amm_writedata(writedata),
        .amm_read(read), .amm_waitrequest(waitreq), .amm_readdata(rdata),
        .amm_readdatavalid(rdv),
        .busy_o(busy), .done_o(done), .error_o(error), .err_addr_o(err_addr)
    );

    // Slave model: s_wait stall cycles per transfer, s_lat 0 = same-cycle read data.
    int          s_wait = 0;
    int          s_lat = 0;
    logic        s_corrupt = 1'b0;
    logic        s_drop = 1'b0;
    logic [RW-1:0] sregs [4];
    int          wcnt = 0;
    logic        pend_q;
    logic [RW-1:0] pdata_q;
    logic        dropped;
    logic [RW-1:0] rd_word;

    always_comb begin
        waitreq = (write || read) && (wcnt < s_wait);
        dropped = s_drop && (address == 4'd1);
        rd_word = (s_corrupt && address == 4'd2) ? 32'hDEADBEEF : sregs[address[1:0]];
        if (s_lat == 0) begin
            rdv   = read && !waitreq && !dropped;
            rdata = rd_word;
        end else begin
            rdv   = pend_q;
            rdata = pdata_q;
        end
    end

    always @(posedge clk) begin
        if ((write || read) && waitreq) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (write && !waitreq) sregs[address[1:0]] <= writedata;
        pend_q  <= (s_lat != 0) && read && !waitreq && !dropped;
        pdata_q <= rd_word;
    end

    // Bus monitor: logs accepted transfers and protocol violations.
    int          held = 0, viol = 0, done_cnt = 0;
    logic        pend = 1'b0, p_w, p_r;
    logic [AW-1:0] p_a;
    logic [RW-1:0] p_d;
    logic [AW-1:0] wl_a[$];
    logic [RW-1:0] wl_d[$];
    logic [AW-1:0] rl_a[$];

    always @(negedge clk) begin
        if (!arst_n) begin
            held = 0;
            pend = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (write && read) viol++;
            if ((write || read) && !busy) viol++;
            if (pend && (write != p_w || read != p_r || address != p_a || writedata != p_d)) viol++;
            pend = 1'b0;
            if (write || read) begin
                held++;
                if (waitreq) begin
                    pend = 1'b1; p_w = write; p_r = read; p_a = address; p_d = writedata;
                end else begin
                    if (held != s_wait + 1) viol++;
                    held = 0;
                    if (write) begin
                        wl_a.push_back(address);
                        wl_d.push_back(writedata);
                    end else begin
                        rl_a.push_back(address);
                    end
                end
            end
        end
    end

    typedef struct {
        logic [RW-1:0] w1, w2, w3;
        logic en, ver;
        int   wt, lat;
        logic corrupt, drop;
        int   exp_done;
        logic exp_err;
        logic [AW-1:0] exp_ea;
    } vec_t;

    vec_t vecs [6];
    int   compared = 0, mismatched = 0;
    int   wl_base, rl_base, done_base, viol_base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic launch(input vec_t v);
        s_wait = v.wt; s_lat = v.lat; s_corrupt = v.corrupt; s_drop = v.drop;
        pattern = {v.w1, v.w2, v.w3};
        enable = v.en; verify = v.ver;
        wl_base = wl_a.size(); rl_base = rl_a.size();
        done_base = done_cnt; viol_base = viol;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("error_cleared_on_start", error, 0);
    endtask

    task automatic complete(input vec_t v, input int c0);
        int cyc, nrd;
        logic got;
        logic [AW-1:0] ea [5];
        logic [RW-1:0] ed [5];
        cyc = c0; got = 1'b0;
        while (cyc < 300 && !got) begin
            @(posedge clk); #1;
            cyc++;
            got = done;
        end
        chk("done_latency", cyc, v.exp_done);
        chk("busy_at_done", busy, 0);
        chk("error", error, v.exp_err);
        chk("err_addr", err_addr, v.exp_ea);
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt - done_base, 1);
        chk("error_held", error, v.exp_err);
        ea = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        ed = '{32'h0, v.w1, v.w2, v.w3, {31'b0, v.en}};
        chk("write_count", wl_a.size() - wl_base, 5);
        if (wl_a.size() - wl_base == 5) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("write%0d_addr", k), wl_a[wl_base+k], ea[k]);
                chk($sformatf("write%0d_data", k), wl_d[wl_base+k], ed[k]);
            end
        end
        nrd = !v.ver ? 0 : (v.drop ? 2 : 4);
        chk("read_count", rl_a.size() - rl_base, nrd);
        if (rl_a.size() - rl_base == nrd) begin
            for (int k = 0; k < nrd; k++) chk($sformatf("read%0d_addr", k), rl_a[rl_base+k], k);
        end
        chk("slave_ctrl", sregs[0], {31'b0, v.en});
        chk("slave_key1", sregs[1], v.w1);
        chk("slave_key2", sregs[2], v.w2);
        chk("slave_key3", sregs[3], v.w3);
        chk("protocol_violations", viol - viol_base, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        vecs[0] = '{32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 6,  1'b0, 4'd0};
        vecs[1] = '{32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 1'b1, 3, 0, 1'b0, 1'b0, 37, 1'b0, 4'd0};
        vecs[2] = '{32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 1'b1, 0, 1, 1'b1, 1'b0, 14, 1'b1, 4'd2};
        vecs[3] = '{32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 24, 1'b1, 4'd1};
        vecs[4] = '{32'hCAFEF00D, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 10, 1'b0, 4'd0};
        vecs[5] = '{32'hCAFEF00D, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1, 1, 1'b0, 1'b0, 23, 1'b0, 4'd0};

        arst_n = 1'b0; start = 1'b0; pattern = '0; enable = 1'b0; verify = 1'b0;
        #12;
        chk("rst_write", write, 0);
        chk("rst_read", read, 0);
        chk("rst_address", address, 0);
        chk("rst_writedata", writedata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_addr", err_addr, 0);
        @(negedge clk) arst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            launch(vecs[i]);
            complete(vecs[i], 0);
        end

        // Stray start with new inputs while busy in WR_PAT must be ignored.
        launch(vecs[0]);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stray_start_in_wr_pat", {write, address}, {1'b1, 4'd2});
        @(negedge clk);
        start = 1'b1; pattern = {32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC};
        enable = 1'b0; verify = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        complete(vecs[0], 3);

        // Reset in the middle of the stalled write to address 2.
        s_wait = 3; s_lat = 0; s_corrupt = 1'b0; s_drop = 1'b0;
        pattern = {32'h01020304, 32'h05060708, 32'h090A0B0C};
        enable = 1'b1; verify = 1'b0;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (k < 100 && !(write && address == 4'd2)) begin
            @(negedge clk);
            k++;
        end
        chk("reached_write_addr2", (k < 100), 1);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_write", write, 0);
        chk("arst_read", read, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_address", address, 0);
        @(negedge clk);
        @(negedge clk) arst_n = 1'b1;
        repeat (2) @(posedge clk);
        launch(vecs[1]);
        complete(vecs[1], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
